// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the shared-multiplier scheduler.
// Provides the FSM state enum, default widths and the id-width helper.
package mult_share_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int DEF_BIT_WIDTH = 6;
    localparam int DEF_OUT_WIDTH = 12;

    // Requester id width; a single bit is kept even for tiny pools.
    function automatic int id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_share_sched_rr_pick.sv
// Round-robin picker: rotate requests by ptr, priority-encode, un-rotate.
// Ports: req_i (request vector), ptr_i (start index), grant_o, any_o.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] grant_o,
    output logic          any_o
);

    logic [N-1:0]  rot;
    logic [IW-1:0] idx;
    logic [IW-1:0] j;

    always_comb begin
        rot   = '0;
        idx   = '0;
        j     = '0;
        any_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            j      = IW'((int'(ptr_i) + i) % N);
            rot[i] = req_i[j];
        end
        // Descending scan leaves the lowest rotated index in idx.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx   = IW'(i);
                any_o = 1'b1;
            end
        end
        grant_o = IW'((int'(ptr_i) + int'(idx)) % N);
    end

endmodule

// File: rtl/top.sv
// Combinational approximate multiplier: signed operand times a fixed
// coefficient, product LSB dropped. Ports: inp (6b signed), out (12b signed).
module top (
    input  logic [5:0]  inp,
    output logic [11:0] out
);

    localparam logic signed [11:0] COEF = -12'sd19;

    logic signed [11:0] a;
    logic signed [11:0] p;

    assign a   = {{6{inp[5]}}, inp};
    assign p   = a * COEF;
    // The approximation: the LSB of the product is never computed.
    assign out = p & 12'hFFE;

endmodule

// File: rtl/mult_share_sched.sv
// Shares one slow multiplier among NUM_REQ requesters, round-robin.
// Ports: req_valid/ready/data in, mult_inp/mult_out to the multiplier,
// rsp_valid/ready/data/id out, busy while a transaction is in flight.
module mult_share_sched
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int BIT_WIDTH     = DEF_BIT_WIDTH,
    parameter int OUT_WIDTH     = DEF_OUT_WIDTH,
    parameter int SETTLE_CYCLES = 2,
    parameter int ID_W          = id_w(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_data,
    output logic [BIT_WIDTH-1:0]         mult_inp,
    input  logic [OUT_WIDTH-1:0]         mult_out,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [OUT_WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]              rsp_id,
    output logic                         busy
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

    state_e                 state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_WIDTH-1:0]   inp_q, inp_d;
    logic [OUT_WIDTH-1:0]   data_q, data_d;
    logic [ID_W-1:0]        grant;
    logic [BIT_WIDTH-1:0]   grant_data;
    logic                   any_valid;
    logic                   accept;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .any_o   (any_valid)
    );

    always_comb begin
        grant_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant == ID_W'(k)) begin
                grant_data = req_data[k*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    // rst_n gates the grant so req_ready reads 0 while reset is held.
    assign accept = rst_n & (state_q == IDLE) & any_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SETTLE;
            SETTLE:  if (cnt_q == '0) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
        rsp_valid = (state_q == RESP);
        busy      = (state_q == SETTLE) || (state_q == RESP);
    end

    always_comb begin
        ptr_d  = ptr_q;
        id_d   = id_q;
        cnt_d  = cnt_q;
        inp_d  = inp_q;
        data_d = data_q;
        if (accept) begin
            inp_d = grant_data;
            id_d  = grant;
            cnt_d = CNT_INIT;
            ptr_d = (grant == LAST_ID) ? '0 : grant + 1'b1;
        end
        // Operand has been stable long enough once cnt reaches zero.
        if (state_q == SETTLE) begin
            if (cnt_q == '0) begin
                data_d = mult_out;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            id_q   <= '0;
            cnt_q  <= '0;
            inp_q  <= '0;
            data_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            id_q   <= id_d;
            cnt_q  <= cnt_d;
            inp_q  <= inp_d;
            data_q <= data_d;
        end
    end

    // inp_q is never cleared after a response so the multiplier stays quiet.
    assign mult_inp = inp_q;
    assign rsp_data = data_q;
    assign rsp_id   = id_q;

endmodule

// File: tb/tb_mult_share_sched.sv
// Scoreboard bench for mult_share_sched (SETTLE_CYCLES=2 and =1 instances).
// Expected products come from an independent instance of the multiplier.
module tb_mult_share_sched;

    localparam int N  = 4;
    localparam int BW = 6;
    localparam int OW = 12;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_ready;
    logic [N*BW-1:0] req_data;
    logic [BW-1:0]   mult_inp;
    logic [OW-1:0]   mult_out;
    logic            rsp_valid, rsp_ready;
    logic [OW-1:0]   rsp_data;
    logic [IW-1:0]   rsp_id;
    logic            busy;

    logic [N-1:0]    req_valid1, req_ready1;
    logic [N*BW-1:0] req_data1;
    logic [BW-1:0]   mult_inp1;
    logic [OW-1:0]   mult_out1;
    logic            rsp_valid1, rsp_ready1;
    logic [OW-1:0]   rsp_data1;
    logic [IW-1:0]   rsp_id1;
    logic            busy1;

    logic [BW-1:0]   ref_inp;
    logic [OW-1:0]   ref_out;

    mult_share_sched #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data),
        .mult_inp(mult_inp), .mult_out(mult_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );
    top u_mul (.inp(mult_inp), .out(mult_out));

    mult_share_sched #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .req_data(req_data1),
        .mult_inp(mult_inp1), .mult_out(mult_out1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_data(rsp_data1), .rsp_id(rsp_id1), .busy(busy1)
    );
    top u_mul1 (.inp(mult_inp1), .out(mult_out1));

    top u_ref (.inp(ref_inp), .out(ref_out));

    typedef struct packed {
        logic [IW-1:0] id;
        logic [OW-1:0] prod;
    } exp_t;

    exp_t sb[$];
    exp_t sb1[$];
    int checks = 0;
    int errors = 0;

    logic          acc, fired, got_v;
    logic [N-1:0]  got_rdy;
    logic [IW-1:0] acc_id, got_id, exp_id;
    logic [OW-1:0] got_d, exp_d;

    logic          acc1, fired1;
    logic [IW-1:0] acc_id1, got_id1, exp_id1;
    logic [OW-1:0] got_d1, exp_d1;

    // One clock of dut: sample, push on accept, pop on response.
    task automatic cycle();
        exp_t e;
        #1;
        got_rdy = req_ready;
        acc = |(req_ready & req_valid);
        acc_id = '0;
        for (int k = 0; k < N; k++)
            if (req_ready[k]) acc_id = IW'(k);
        if (acc) begin
            ref_inp = req_data[int'(acc_id)*BW +: BW];
            #1;
            sb.push_back({acc_id, ref_out});
        end
        got_v = rsp_valid;
        fired = rsp_valid & rsp_ready;
        got_id = rsp_id;
        got_d = rsp_data;
        if (fired) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                exp_id = e.id;
                exp_d = e.prod;
            end else begin
                exp_id = 'x;
                exp_d = 'x;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle1();
        exp_t e;
        #1;
        acc1 = |(req_ready1 & req_valid1);
        acc_id1 = '0;
        for (int k = 0; k < N; k++)
            if (req_ready1[k]) acc_id1 = IW'(k);
        if (acc1) begin
            ref_inp = req_data1[int'(acc_id1)*BW +: BW];
            #1;
            sb1.push_back({acc_id1, ref_out});
        end
        fired1 = rsp_valid1 & rsp_ready1;
        got_id1 = rsp_id1;
        got_d1 = rsp_data1;
        if (fired1) begin
            if (sb1.size() > 0) begin
                e = sb1.pop_front();
                exp_id1 = e.id;
                exp_d1 = e.prod;
            end else begin
                exp_id1 = 'x;
                exp_d1 = 'x;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int vcnt;
        rst_n = 1'b0;
        req_valid = '1;
        #2;
        checks++;
        if (req_ready !== '0) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=0000", req_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got v=%b busy=%b v1=%b exp 0",
                     rsp_valid, busy, rsp_valid1);
        end
        checks++;
        if (mult_inp !== '0 || rsp_id !== '0 || rsp_data !== '0) begin
            errors++;
            $display("FAIL reset_regs got inp=%h id=%0d data=%h exp 0",
                     mult_inp, rsp_id, rsp_data);
        end
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 4'b0100;
        req_data[2*BW +: BW] = 6'b101011;
        cycle();
        checks++;
        if (!acc || acc_id !== 2'd2) begin
            errors++;
            $display("FAIL rstmid_grant got acc=%b id=%0d exp 1/2", acc, acc_id);
        end
        req_valid = '0;
        cycle();
        rst_n = 1'b0;
        #1;
        checks++;
        if (mult_inp !== '0 || rsp_id !== '0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_clear got inp=%h id=%0d busy=%b v=%b exp 0",
                     mult_inp, rsp_id, busy, rsp_valid);
        end
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (got_v) vcnt++;
        end
        checks++;
        if (vcnt != 0) begin
            errors++;
            $display("FAIL rstmid_norsp got %0d responses exp 0", vcnt);
        end
        req_valid = 4'b1010;
        req_data[1*BW +: BW] = 6'd9;
        req_data[3*BW +: BW] = 6'h3c;
        cycle();
        checks++;
        if (!acc || acc_id !== 2'd1) begin
            errors++;
            $display("FAIL rstmid_first got acc=%b id=%0d exp 1/1", acc, acc_id);
        end
        req_valid = '0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (fired) begin
                checks++;
                if (got_id !== exp_id || got_d !== exp_d) begin
                    errors++;
                    $display("FAIL rstmid_rsp got id=%0d data=%h exp id=%0d data=%h",
                             got_id, got_d, exp_id, exp_d);
                end
            end
        end
    endtask

    task automatic test_single();
        int rcnt, vcnt, lat;
        rsp_ready = 1'b1;
        req_valid = 4'b0010;
        req_data[BW +: BW] = 6'd13;
        cycle();
        checks++;
        if (!acc || acc_id !== 2'd1) begin
            errors++;
            $display("FAIL single_grant got acc=%b id=%0d exp 1/1", acc, acc_id);
        end
        rcnt = got_rdy[1] ? 1 : 0;
        req_valid = '0;
        checks++;
        if (mult_inp !== 6'd13 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_inp got inp=%h busy=%b exp 0d/1", mult_inp, busy);
        end
        vcnt = 0;
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            if (got_rdy[1]) rcnt++;
            if (got_v) begin
                vcnt++;
                if (lat < 0) lat = i;
            end
            if (fired) begin
                checks++;
                if (got_id !== exp_id || got_d !== exp_d) begin
                    errors++;
                    $display("FAIL single_rsp got id=%0d data=%h exp id=%0d data=%h",
                             got_id, got_d, exp_id, exp_d);
                end
            end
        end
        checks++;
        if (rcnt != 1 || vcnt != 1 || lat != 3) begin
            errors++;
            $display("FAIL single_timing got ready=%0d valid=%0d lat=%0d exp 1/1/3",
                     rcnt, vcnt, lat);
        end
    endtask

    task automatic test_contention();
        logic [IW-1:0] ids[5];
        int at[5];
        int nf;
        rst_n = 1'b0;
        #1;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_data = {6'd5, 6'h3f, 6'd22, 6'h39};
        req_valid = '1;
        rsp_ready = 1'b1;
        nf = 0;
        for (int i = 0; i < 40 && nf < 5; i++) begin
            cycle();
            if (fired) begin
                checks++;
                if (got_id !== exp_id || got_d !== exp_d) begin
                    errors++;
                    $display("FAIL contend_rsp got id=%0d data=%h exp id=%0d data=%h",
                             got_id, got_d, exp_id, exp_d);
                end
                ids[nf] = got_id;
                at[nf] = i;
                nf++;
            end
        end
        req_valid = '0;
        checks++;
        if (nf != 5) begin
            errors++;
            $display("FAIL contend_count got %0d responses exp 5", nf);
        end
        for (int k = 0; k < nf; k++) begin
            checks++;
            if (ids[k] !== IW'(k % N)) begin
                errors++;
                $display("FAIL contend_order[%0d] got id=%0d exp %0d", k, ids[k], k % N);
            end
        end
        for (int k = 1; k < nf; k++) begin
            checks++;
            if (at[k] - at[k-1] != 4) begin
                errors++;
                $display("FAIL contend_gap[%0d] got %0d exp 4", k, at[k] - at[k-1]);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL contend_left got %0d pending exp 0", sb.size());
        end
    endtask

    task automatic test_rr_wrap();
        logic got3;
        req_valid = 4'b1000;
        req_data[3*BW +: BW] = 6'h2a;
        cycle();
        checks++;
        if (!acc || acc_id !== 2'd3) begin
            errors++;
            $display("FAIL rr_serve3 got acc=%b id=%0d exp 1/3", acc, acc_id);
        end
        req_valid = '0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (fired) begin
                checks++;
                if (got_id !== exp_id || got_d !== exp_d) begin
                    errors++;
                    $display("FAIL rr_rsp3 got id=%0d data=%h exp id=%0d data=%h",
                             got_id, got_d, exp_id, exp_d);
                end
            end
        end
        req_valid = 4'b1001;
        req_data[0 +: BW] = 6'd11;
        cycle();
        checks++;
        if (!acc || acc_id !== 2'd0) begin
            errors++;
            $display("FAIL rr_wrap got acc=%b id=%0d exp 1/0", acc, acc_id);
        end
        req_valid = 4'b1000;
        got3 = 1'b0;
        for (int i = 0; i < 10 && !got3; i++) begin
            cycle();
            if (fired) begin
                checks++;
                if (got_id !== exp_id || got_d !== exp_d) begin
                    errors++;
                    $display("FAIL rr_rsp0 got id=%0d data=%h exp id=%0d data=%h",
                             got_id, got_d, exp_id, exp_d);
                end
            end
            if (acc) got3 = 1'b1;
        end
        req_valid = '0;
        checks++;
        if (!got3 || acc_id !== 2'd3) begin
            errors++;
            $display("FAIL rr_next got acc=%b id=%0d exp 1/3", got3, acc_id);
        end
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (fired) begin
                checks++;
                if (got_id !== exp_id || got_d !== exp_d) begin
                    errors++;
                    $display("FAIL rr_rsp3b got id=%0d data=%h exp id=%0d data=%h",
                             got_id, got_d, exp_id, exp_d);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic seen;
        req_valid = 4'b0001;
        req_data[0 +: BW] = 6'h37;
        rsp_ready = 1'b0;
        cycle();
        checks++;
        if (!acc || acc_id !== 2'd0) begin
            errors++;
            $display("FAIL bp_accept got acc=%b id=%0d exp 1/0", acc, acc_id);
        end
        req_data[0 +: BW] = 6'd17;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            if (got_v) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_valid got no rsp_valid exp 1");
        end
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if (sb.size() == 0 || !got_v || got_id !== sb[0].id ||
                got_d !== sb[0].prod || got_rdy !== '0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%b id=%0d data=%h rdy=%b",
                         i, got_v, got_id, got_d, got_rdy);
            end
        end
        rsp_ready = 1'b1;
        cycle();
        checks++;
        if (!fired || got_id !== exp_id || got_d !== exp_d || got_rdy !== '0) begin
            errors++;
            $display("FAIL bp_release got f=%b id=%0d data=%h rdy=%b exp id=%0d data=%h",
                     fired, got_id, got_d, got_rdy, exp_id, exp_d);
        end
        cycle();
        checks++;
        if (!acc || acc_id !== 2'd0) begin
            errors++;
            $display("FAIL bp_next got acc=%b id=%0d exp 1/0", acc, acc_id);
        end
        req_valid = '0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (fired) begin
                checks++;
                if (got_id !== exp_id || got_d !== exp_d) begin
                    errors++;
                    $display("FAIL bp_rsp2 got id=%0d data=%h exp id=%0d data=%h",
                             got_id, got_d, exp_id, exp_d);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL bp_left got %0d pending exp 0", sb.size());
        end
    endtask

    task automatic test_settle1_boundary();
        logic [BW-1:0] ops[3];
        int lat;
        ops[0] = 6'h20;
        ops[1] = 6'h1f;
        ops[2] = 6'h00;
        rsp_ready1 = 1'b1;
        for (int t = 0; t < 3; t++) begin
            req_valid1 = 4'b0001;
            req_data1[0 +: BW] = ops[t];
            cycle1();
            checks++;
            if (!acc1 || acc_id1 !== 2'd0) begin
                errors++;
                $display("FAIL s1_accept[%0d] got acc=%b id=%0d exp 1/0",
                         t, acc1, acc_id1);
            end
            req_valid1 = '0;
            checks++;
            if (mult_inp1 !== ops[t]) begin
                errors++;
                $display("FAIL s1_inp[%0d] got %h exp %h", t, mult_inp1, ops[t]);
            end
            lat = -1;
            for (int i = 1; i <= 6; i++) begin
                cycle1();
                if (fired1) begin
                    lat = i;
                    checks++;
                    if (got_id1 !== exp_id1 || got_d1 !== exp_d1) begin
                        errors++;
                        $display("FAIL s1_rsp[%0d] got id=%0d data=%h exp id=%0d data=%h",
                                 t, got_id1, got_d1, exp_id1, exp_d1);
                    end
                end
            end
            checks++;
            if (lat != 2) begin
                errors++;
                $display("FAIL s1_latency[%0d] got %0d exp 2", t, lat);
            end
        end
    endtask

    initial begin
        req_valid = '0;
        req_data = '0;
        rsp_ready = 1'b0;
        req_valid1 = '0;
        req_data1 = '0;
        rsp_ready1 = 1'b0;
        ref_inp = '0;
        test_reset();
        test_single();
        test_contention();
        test_rr_wrap();
        test_backpressure();
        test_settle1_boundary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
